// File: rtl/fetch_pc_unit.sv
// Program-counter owner and instruction fetcher feeding main_control.
// Handshakes with instruction memory via req/ack and resolves the next PC from branch/jump controls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request instruction at pc, wait for imem_ack
// ST_EXEC  | latched instruction executing, instr_valid high
// ST_TRAP  | misaligned control-flow target seen, halted until rst
module fetch_pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] NOP_INSTR = 'h13
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic [6:0]       opcode,
   output logic             instr_valid,
   input  logic             stall,
   input  logic             branch,
   input  logic             salto_incon,
   input  logic             flag_direccion,
   input  logic             zero,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rs1_data,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             trap
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic             trap_q, trap_d;

   logic             taken;
   logic [WIDTH-1:0] target_base;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] next_pc;

   // Bit 0 of the target is always cleared so jalr-style targets land on halfword boundaries.
   always_comb begin
      taken       = branch & (salto_incon | zero);
      target_base = flag_direccion ? rs1_data : pc_q;
      target      = (target_base + imm) & ~{{(WIDTH-1){1'b0}}, 1'b1};
      next_pc     = taken ? target : (pc_q + WIDTH'(4));
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      trap_d  = trap_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               instr_d = NOP_INSTR;
               if (next_pc[1]) begin
                  trap_d  = 1'b1;
                  state_d = ST_TRAP;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_TRAP: begin
            instr_d = NOP_INSTR;
         end
         default: begin
            state_d = ST_FETCH;
            instr_d = NOP_INSTR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         trap_q  <= trap_d;
      end
   end

   // Request is masked by rst directly so it drops in the very cycle reset is asserted.
   assign imem_req    = (state_q == ST_FETCH) && !rst;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign instr_valid = (state_q == ST_EXEC);
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + WIDTH'(4);
   assign trap        = trap_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: an instruction-memory responder drives fetches,
// a scoreboard queue holds the expected pc/instr of each instruction until it reaches EXEC.
module tb_fetch_pc_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic        instr_valid;
   logic        stall;
   logic        branch;
   logic        salto_incon;
   logic        flag_direccion;
   logic        zero;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        trap;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;

   fetch_pc_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr          (instr),
      .opcode         (opcode),
      .instr_valid    (instr_valid),
      .stall          (stall),
      .branch         (branch),
      .salto_incon    (salto_incon),
      .flag_direccion (flag_direccion),
      .zero           (zero),
      .imm            (imm),
      .rs1_data       (rs1_data),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .trap           (trap)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_ctrl();
      stall          = 1'b0;
      branch         = 1'b0;
      salto_incon    = 1'b0;
      flag_direccion = 1'b0;
      zero           = 1'b0;
      imm            = 32'h0;
      rs1_data       = 32'h0;
   endtask

   // One full fetch+execute; inputs change at negedge, outputs sampled at negedge.
   task automatic run_instr(input logic [31:0] rdata, input int lat, input int nstall,
                            input logic br, input logic sj, input logic fd, input logic z,
                            input logic [31:0] im, input logic [31:0] rs1,
                            input logic [31:0] exp_next, input logic exp_trap);
      exp_t e;
      int   waited;
      int   valid_cnt;
      e.pc    = exp_pc;
      e.instr = rdata;
      sb_q.push_back(e);
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
      end
      checks++;
      if (imem_addr !== exp_pc) begin
         errors++;
         $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_pc);
      end
      for (int i = 0; i < lat; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: req=%b addr=%h valid=%b required 1 %h 0",
                     imem_req, imem_addr, instr_valid, exp_pc);
         end
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL exec_valid: got %b required 1", instr_valid);
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries required 1");
      end else begin
         e = sb_q.pop_front();
         checks++;
         if (pc !== e.pc || instr !== e.instr || opcode !== e.instr[6:0]) begin
            errors++;
            $display("FAIL exec_instr: pc=%h instr=%h op=%h required %h %h %h",
                     pc, instr, opcode, e.pc, e.instr, e.instr[6:0]);
         end
         checks++;
         if (pc_plus4 !== e.pc + 32'd4) begin
            errors++;
            $display("FAIL pc_plus4: got %h required %h", pc_plus4, e.pc + 32'd4);
         end
      end
      valid_cnt = 1;
      for (int i = 0; i < nstall; i++) begin
         stall      = 1'b1;
         imem_ack   = 1'b1;
         imem_rdata = 32'h0BAD_0BAD;
         @(negedge clk);
         if (instr_valid === 1'b1) valid_cnt++;
         checks++;
         if (pc !== e.pc || instr !== e.instr) begin
            errors++;
            $display("FAIL stall_hold: pc=%h instr=%h required %h %h", pc, instr, e.pc, e.instr);
         end
      end
      stall          = 1'b0;
      imem_ack       = 1'b0;
      branch         = br;
      salto_incon    = sj;
      flag_direccion = fd;
      zero           = z;
      imm            = im;
      rs1_data       = rs1;
      @(negedge clk);
      clear_ctrl();
      checks++;
      if (instr_valid !== 1'b0 || valid_cnt != 1 + nstall) begin
         errors++;
         $display("FAIL valid_len: valid=%b cycles=%0d required 0 %0d",
                  instr_valid, valid_cnt, 1 + nstall);
      end
      checks++;
      if (pc !== exp_next || instr !== NOP || trap !== exp_trap) begin
         errors++;
         $display("FAIL next_pc: pc=%h instr=%h trap=%b required %h %h %b",
                  pc, instr, trap, exp_next, NOP, exp_trap);
      end
      exp_pc = exp_next;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (pc !== 32'h0 || instr !== NOP || imem_req !== 1'b0 || instr_valid !== 1'b0 || trap !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pc=%h instr=%h req=%b valid=%b trap=%b required 0 %h 0 0 0",
                  pc, instr, imem_req, instr_valid, trap, NOP);
      end
      rst    = 1'b0;
      exp_pc = 32'h0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_release: req=%b addr=%h required 1 0", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      run_instr(32'h0010_0093, 0, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h4, 0);
      run_instr(32'h0020_0113, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 0);
      // branch low gates salto_incon and zero
      run_instr(32'h0030_0193, 1, 0, 0, 1, 0, 1, 32'h80, 32'h0, 32'hC, 0);
      run_instr(32'h0040_0213, 2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 0);
   endtask

   task automatic test_branch();
      run_instr(32'hFE00_0CE3, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 32'h8, 0);
      run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0);
      run_instr(32'h0000_0013, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 0);
      run_instr(32'hFE00_0CE3, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h14, 0);
      run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h18, 0);
      run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1C, 0);
      run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h20, 0);
   endtask

   task automatic test_jal();
      run_instr(32'h1000_00EF, 1, 0, 1, 1, 0, 0, 32'h100, 32'h0, 32'h120, 0);
   endtask

   task automatic test_stall();
      run_instr(32'h0055_0533, 0, 3, 0, 0, 0, 0, 32'h0, 32'h0, 32'h124, 0);
   endtask

   task automatic test_jalr_trap();
      run_instr(32'h0000_8067, 0, 0, 1, 1, 1, 0, 32'h0, 32'h1001, 32'h1000, 0);
      run_instr(32'h0000_8067, 2, 0, 1, 1, 1, 0, 32'h0, 32'h1002, 32'h1000, 1);
      for (int i = 0; i < 4; i++) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'h1234_5678;
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b0 || trap !== 1'b1 ||
             instr !== NOP || pc !== 32'h1000) begin
            errors++;
            $display("FAIL trap_hold: req=%b valid=%b trap=%b instr=%h pc=%h required 0 0 1 %h 00001000",
                     imem_req, instr_valid, trap, instr, pc, NOP);
         end
      end
      imem_ack = 1'b0;
      test_reset();
   endtask

   task automatic test_rst_mid_fetch();
      run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      rst        = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_fetch_req: got %b required 0", imem_req);
      end
      @(negedge clk);
      checks++;
      if (pc !== 32'h0 || instr !== NOP || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_fetch_state: pc=%h instr=%h valid=%b required 0 %h 0", pc, instr, instr_valid, NOP);
      end
      imem_ack = 1'b0;
      rst      = 1'b0;
      exp_pc   = 32'h0;
      run_instr(32'h0000_0093, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0);
   endtask

   initial begin
      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      exp_pc     = 32'h0;
      clear_ctrl();
      test_reset();
      test_sequential();
      test_branch();
      test_jal();
      test_stall();
      test_jalr_trap();
      test_rst_mid_fetch();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
